m68k_bus_ctrl: RTL and testbench
================================

// Module: m68k_bus_ctrl
// PURPOSE
//  Bus-cycle controller for the fx68k system bus. Decodes each 68000 bus cycle by address page,
//  drives chip selects, and inserts per-region wait states before DTACKn. Requests VPAn for the
//  6800-style peripheral pages. Terminates cycles to unmapped pages, or stuck cycles, with BERRn.
//  Sits between the CPU strobes and the ROM/RAM/ACIA/LED/GPIO blocks; replaces free-running DTACK.
// PARAMETERS
//  ROM_WAIT  1    wait cycles before DTACKn for page 0 (ROM), 0..15
//  RAM_WAIT  1    wait cycles before DTACKn for page 1 (RAM), 0..15
//  TIMEOUT   255  cycles with AS asserted and no termination before BERRn, 16..1023
// PORTS
//  clk        in   1   system clock (25 MHz)
//  rst_n      in   1   asynchronous active-low reset
//  as_n       in   1   CPU address strobe
//  rw         in   1   CPU read=1 / write=0
//  uds_n      in   1   upper data strobe
//  lds_n      in   1   lower data strobe
//  vma_n      in   1   CPU valid memory address (VPA cycles)
//  addr_page  in   4   cpu_addr[15:12]
//  dtack_n    out  1   data transfer acknowledge to CPU
//  vpa_n      out  1   valid peripheral address to CPU
//  berr_n     out  1   bus error to CPU
//  rom_cs     out  1   ROM select
//  ram_cs     out  1   RAM select
//  ram_we     out  1   ram_cs & !rw
//  ram_mask   out  2   {!uds_n, !lds_n}, qualified by ram_we
//  led_cs     out  1   page 2 select, qualified by !vma_n
//  acia_cs    out  1   page 3 select, qualified by !vma_n
//  gpio_cs    out  1   page 4 select, qualified by !vma_n
//  fault_page out  4   page of the most recent BERR cycle
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, counter 0, dtack_n=vpa_n=berr_n=1, all cs/we 0,
//    ram_mask 0, fault_page 0. Takes effect immediately, including mid-cycle.
//  - All handshake outputs are registered. Selects decode from the latched page register.
//  - Page latch: page is captured on the IDLE edge where as_n is sampled low (edge k).
//  - Region map: page 0 ROM, 1 RAM, 2..4 PERIPH, 5..15 UNMAPPED.
//  - FSM states: IDLE, MEM, PERIPH, TERM, UNMAP.
//  - IDLE -> MEM (page 0/1), loading cnt=ROM_WAIT or RAM_WAIT.
//  - IDLE -> PERIPH (page 2..4), with vpa_n<=0 at edge k.
//  - IDLE -> UNMAP (page 5..15), loading cnt=TIMEOUT.
//  - MEM: cnt decrements each edge. On the edge where cnt==0, dtack_n<=0 and go to TERM.
//    dtack_n falls at edge k+1+WAIT. With WAIT=0, dtack_n falls at edge k+1.
//  - rom_cs/ram_cs assert from edge k until return to IDLE.
//  - PERIPH: vpa_n held 0 and the timeout counter runs. The CPU E/VMA handshake completes the
//    cycle; led/acia/gpio_cs are high only while the page matches and vma_n=0.
//    If cnt reaches 0 first: berr_n<=0, vpa_n<=1, go to TERM.
//  - UNMAP: when cnt reaches 0, berr_n<=0 and fault_page<=page; go to TERM.
//  - TERM: hold the asserted termination until as_n is sampled high.
//    On that edge: dtack_n=vpa_n=berr_n<=1, cs<=0, go to IDLE.
//  - Abort: as_n sampled high in MEM/PERIPH/UNMAP -> IDLE and deassert all, without DTACK/BERR.
//  - Back-to-back: as_n must be sampled high at least once in IDLE before a new cycle starts.
//    A strobe still low on return to IDLE starts no cycle.
//  - dtack_n and berr_n are never low together. vpa_n and dtack_n are never low together.
//  - Counter: width $clog2(TIMEOUT+1), unsigned. Loads never exceed TIMEOUT; no wrap.
// STRUCTURE
//  - Package m68k_bus_pkg: page constants (PAGE_ROM=0, PAGE_RAM=1, PAGE_LED=2, PAGE_ACIA=3,
//    PAGE_GPIO=4) and the FSM state encoding.
//  - One sub-module, bus_timer: loadable down-counter with a zero flag, shared by the wait and
//    timeout paths.
//  - Top-level wiring: the top replaces its dtack/vpa logic with this block and ties BERRn to berr_n.
// TESTING
//  1. ROM read, ROM_WAIT=1: as_n low at edge k, page 0 -> rom_cs=1 from k; dtack_n=0 at k+2;
//     as_n high -> all released on the next edge.
//  2. RAM write, RAM_WAIT=0, uds_n=0, lds_n=1 -> ram_we=1, ram_mask=2'b10, dtack_n=0 at k+1.
//  3. ACIA access, page 3: vpa_n=0 at k, dtack_n stays 1; acia_cs=1 only while vma_n=0;
//     release on as_n high.
//  4. Unmapped page 7, TIMEOUT=20 -> berr_n=0 at edge k+21, fault_page=7, dtack_n stays 1.
//  5. RAM_WAIT=5, as_n released at k+3 -> no dtack_n pulse; IDLE at k+4.
//     rst_n pulsed low mid-cycle -> all outputs deasserted asynchronously.
//  6. Held as_n across TERM->IDLE -> no second cycle until as_n goes high then low.

Source files
------------

// File: rtl/m68k_bus_ctrl_pkg.sv
// m68k_bus_pkg
//   Shared definitions for the 68000 bus-cycle controller: address-page
//   constants, region classification and the controller FSM state encoding.
package m68k_bus_pkg;

  localparam logic [3:0] PAGE_ROM  = 4'd0;
  localparam logic [3:0] PAGE_RAM  = 4'd1;
  localparam logic [3:0] PAGE_LED  = 4'd2;
  localparam logic [3:0] PAGE_ACIA = 4'd3;
  localparam logic [3:0] PAGE_GPIO = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM    = 3'd1,
    ST_PERIPH = 3'd2,
    ST_TERM   = 3'd3,
    ST_UNMAP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    REG_ROM    = 2'd0,
    REG_RAM    = 2'd1,
    REG_PERIPH = 2'd2,
    REG_UNMAP  = 2'd3
  } region_t;

  // Classify an address page into the region that decides the cycle type.
  function automatic region_t page_region(input logic [3:0] page);
    region_t r;
    case (page)
      PAGE_ROM:                       r = REG_ROM;
      PAGE_RAM:                       r = REG_RAM;
      PAGE_LED, PAGE_ACIA, PAGE_GPIO: r = REG_PERIPH;
      default:                        r = REG_UNMAP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/m68k_bus_ctrl_timer.sv
// bus_timer
//   Loadable down-counter with a zero flag. Used both for memory wait states
//   and for the bus-error timeout. Load has priority over decrement; the
//   counter holds at zero rather than wrapping.
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset (counter -> 0)
//   i_load      load i_load_val this edge
//   i_load_val  value to load
//   i_dec       decrement this edge (ignored when already zero)
//   o_zero      counter is zero
module bus_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;
  logic         w_zero;

  assign w_zero = (r_cnt == '0);
  assign o_zero = w_zero;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && !w_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// m68k_bus_ctrl
//   Bus-cycle controller for the fx68k system bus. Latches the address page at
//   the start of each cycle, drives chip selects, inserts per-region wait
//   states before DTACKn, requests VPAn for 6800-style peripherals and ends
//   unmapped or stuck cycles with BERRn.
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_as_n, i_rw             CPU address strobe, read(1)/write(0)
//   i_uds_n, i_lds_n         CPU data strobes
//   i_vma_n                  CPU valid memory address (VPA cycles)
//   i_addr_page              cpu_addr[15:12]
//   o_dtack_n, o_vpa_n,
//   o_berr_n                 registered handshake outputs to the CPU
//   o_rom_cs, o_ram_cs       memory selects (decoded from latched page)
//   o_ram_we, o_ram_mask     RAM write enable and byte-lane mask
//   o_led_cs, o_acia_cs,
//   o_gpio_cs                peripheral selects, qualified by !vma_n
//   o_fault_page             page of the most recent bus-error cycle
module m68k_bus_ctrl
  import m68k_bus_pkg::*;
#(
  parameter int ROM_WAIT = 1,
  parameter int RAM_WAIT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_as_n,
  input  logic       i_rw,
  input  logic       i_uds_n,
  input  logic       i_lds_n,
  input  logic       i_vma_n,
  input  logic [3:0] i_addr_page,
  output logic       o_dtack_n,
  output logic       o_vpa_n,
  output logic       o_berr_n,
  output logic       o_rom_cs,
  output logic       o_ram_cs,
  output logic       o_ram_we,
  output logic [1:0] o_ram_mask,
  output logic       o_led_cs,
  output logic       o_acia_cs,
  output logic       o_gpio_cs,
  output logic [3:0] o_fault_page
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] L_ROM_WAIT = CW'(ROM_WAIT);
  localparam logic [CW-1:0] L_RAM_WAIT = CW'(RAM_WAIT);
  localparam logic [CW-1:0] L_TIMEOUT  = CW'(TIMEOUT);

  state_t      r_state, w_state_next;
  logic [3:0]  r_page, w_page_next;
  logic [3:0]  r_fault_page, w_fault_page_next;
  logic        r_dtack_n, w_dtack_n_next;
  logic        r_vpa_n, w_vpa_n_next;
  logic        r_berr_n, w_berr_n_next;
  // Set once as_n has been sampled high in IDLE; a cycle may only start
  // while set, so a strobe still low after termination cannot retrigger.
  logic        r_armed, w_armed_next;

  logic          w_tmr_load;
  logic [CW-1:0] w_tmr_val;
  logic          w_tmr_dec;
  logic          w_tmr_zero;

  bus_timer #(.W(CW)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_page       <= 4'd0;
      r_fault_page <= 4'd0;
      r_dtack_n    <= 1'b1;
      r_vpa_n      <= 1'b1;
      r_berr_n     <= 1'b1;
      r_armed      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_page       <= w_page_next;
      r_fault_page <= w_fault_page_next;
      r_dtack_n    <= w_dtack_n_next;
      r_vpa_n      <= w_vpa_n_next;
      r_berr_n     <= w_berr_n_next;
      r_armed      <= w_armed_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_page_next       = r_page;
    w_fault_page_next = r_fault_page;
    w_dtack_n_next    = r_dtack_n;
    w_vpa_n_next      = r_vpa_n;
    w_berr_n_next     = r_berr_n;
    w_armed_next      = r_armed;
    w_tmr_load        = 1'b0;
    w_tmr_val         = '0;
    w_tmr_dec         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_as_n) begin
          w_armed_next = 1'b1;
        end else if (r_armed) begin
          w_armed_next = 1'b0;
          w_page_next  = i_addr_page;
          w_tmr_load   = 1'b1;
          case (page_region(i_addr_page))
            REG_ROM: begin
              w_state_next = ST_MEM;
              w_tmr_val    = L_ROM_WAIT;
            end
            REG_RAM: begin
              w_state_next = ST_MEM;
              w_tmr_val    = L_RAM_WAIT;
            end
            REG_PERIPH: begin
              w_state_next = ST_PERIPH;
              w_vpa_n_next = 1'b0;
              w_tmr_val    = L_TIMEOUT;
            end
            default: begin
              w_state_next = ST_UNMAP;
              w_tmr_val    = L_TIMEOUT;
            end
          endcase
        end
      end

      // Strobe release aborts before any termination is considered.
      ST_MEM: begin
        if (i_as_n) begin
          w_state_next = ST_IDLE;
        end else if (w_tmr_zero) begin
          w_dtack_n_next = 1'b0;
          w_state_next   = ST_TERM;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      ST_PERIPH: begin
        if (i_as_n) begin
          w_vpa_n_next = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_tmr_zero) begin
          w_berr_n_next = 1'b0;
          w_vpa_n_next  = 1'b1;
          w_state_next  = ST_TERM;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      ST_UNMAP: begin
        if (i_as_n) begin
          w_state_next = ST_IDLE;
        end else if (w_tmr_zero) begin
          w_berr_n_next     = 1'b0;
          w_fault_page_next = r_page;
          w_state_next      = ST_TERM;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      ST_TERM: begin
        if (i_as_n) begin
          w_dtack_n_next = 1'b1;
          w_vpa_n_next   = 1'b1;
          w_berr_n_next  = 1'b1;
          w_state_next   = ST_IDLE;
        end
      end

      default: begin
        w_dtack_n_next = 1'b1;
        w_vpa_n_next   = 1'b1;
        w_berr_n_next  = 1'b1;
        w_state_next   = ST_IDLE;
      end
    endcase
  end

  // Selects come from registered state and the latched page, so they are
  // glitch-free with respect to the address bus and clear on async reset.
  logic w_active;
  logic w_ram_cs;
  logic w_vma;

  assign w_active = (r_state != ST_IDLE);
  assign w_ram_cs = w_active && (r_page == PAGE_RAM);
  assign w_vma    = !i_vma_n;

  assign o_rom_cs     = w_active && (r_page == PAGE_ROM);
  assign o_ram_cs     = w_ram_cs;
  assign o_ram_we     = w_ram_cs && !i_rw;
  assign o_ram_mask   = {!i_uds_n, !i_lds_n} & {2{o_ram_we}};
  assign o_led_cs     = w_active && w_vma && (r_page == PAGE_LED);
  assign o_acia_cs    = w_active && w_vma && (r_page == PAGE_ACIA);
  assign o_gpio_cs    = w_active && w_vma && (r_page == PAGE_GPIO);
  assign o_dtack_n    = r_dtack_n;
  assign o_vpa_n      = r_vpa_n;
  assign o_berr_n     = r_berr_n;
  assign o_fault_page = r_fault_page;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
module tb_m68k_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       as_n = 1'b1;
  logic       rw = 1'b1;
  logic       uds_n = 1'b1;
  logic       lds_n = 1'b1;
  logic       vma_n = 1'b1;
  logic [3:0] page = 4'd0;

  // DUT A: ROM_WAIT=1, RAM_WAIT=0, TIMEOUT=20
  logic       a_dtack_n, a_vpa_n, a_berr_n, a_rom_cs, a_ram_cs, a_ram_we;
  logic [1:0] a_ram_mask;
  logic       a_led_cs, a_acia_cs, a_gpio_cs;
  logic [3:0] a_fault_page;
  // DUT B: RAM_WAIT=5 for the abort case
  logic       b_dtack_n, b_vpa_n, b_berr_n, b_rom_cs, b_ram_cs, b_ram_we;
  logic [1:0] b_ram_mask;
  logic       b_led_cs, b_acia_cs, b_gpio_cs;
  logic [3:0] b_fault_page;

  m68k_bus_ctrl #(.ROM_WAIT(1), .RAM_WAIT(0), .TIMEOUT(20)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_as_n(as_n), .i_rw(rw),
    .i_uds_n(uds_n), .i_lds_n(lds_n), .i_vma_n(vma_n), .i_addr_page(page),
    .o_dtack_n(a_dtack_n), .o_vpa_n(a_vpa_n), .o_berr_n(a_berr_n),
    .o_rom_cs(a_rom_cs), .o_ram_cs(a_ram_cs), .o_ram_we(a_ram_we),
    .o_ram_mask(a_ram_mask), .o_led_cs(a_led_cs), .o_acia_cs(a_acia_cs),
    .o_gpio_cs(a_gpio_cs), .o_fault_page(a_fault_page)
  );

  m68k_bus_ctrl #(.ROM_WAIT(1), .RAM_WAIT(5), .TIMEOUT(20)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_as_n(as_n), .i_rw(rw),
    .i_uds_n(uds_n), .i_lds_n(lds_n), .i_vma_n(vma_n), .i_addr_page(page),
    .o_dtack_n(b_dtack_n), .o_vpa_n(b_vpa_n), .o_berr_n(b_berr_n),
    .o_rom_cs(b_rom_cs), .o_ram_cs(b_ram_cs), .o_ram_we(b_ram_we),
    .o_ram_mask(b_ram_mask), .o_led_cs(b_led_cs), .o_acia_cs(b_acia_cs),
    .o_gpio_cs(b_gpio_cs), .o_fault_page(b_fault_page)
  );

  always #5 clk = ~clk;

  logic [14:0] a_vec, b_vec;
  assign a_vec = {a_dtack_n, a_vpa_n, a_berr_n, a_rom_cs, a_ram_cs, a_ram_we,
                  a_ram_mask, a_led_cs, a_acia_cs, a_gpio_cs, a_fault_page};
  assign b_vec = {b_dtack_n, b_vpa_n, b_berr_n, b_rom_cs, b_ram_cs, b_ram_we,
                  b_ram_mask, b_led_cs, b_acia_cs, b_gpio_cs, b_fault_page};

  int total = 0;
  int bad = 0;

  function automatic logic [14:0] mk(input logic d, input logic v, input logic b,
                                     input logic rom, input logic ram, input logic we,
                                     input logic [1:0] m, input logic led,
                                     input logic acia, input logic gpio,
                                     input logic [3:0] fp);
    return {d, v, b, rom, ram, we, m, led, acia, gpio, fp};
  endfunction

  typedef struct {
    string       name;
    logic        as_n;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic        vma_n;
    logic [3:0]  page;
    logic [14:0] exp;
  } vec_t;

  function automatic vec_t mv(input string n, input logic a, input logic r,
                              input logic u, input logic l, input logic vm,
                              input logic [3:0] pg, input logic [14:0] e);
    vec_t t;
    t.name = n; t.as_n = a; t.rw = r; t.uds_n = u; t.lds_n = l;
    t.vma_n = vm; t.page = pg; t.exp = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [14:0] got, input logic [14:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end else begin
      $display("ok   %s: got=%h", name, got);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, exp);
    end else begin
      $display("ok   %s: got=%b", name, got);
    end
  endtask

  // Advance one edge, sample 1 ns later, and check handshake exclusivity.
  task automatic tick();
    @(posedge clk);
    #1;
    total++;
    if ((!a_dtack_n && !a_berr_n) || (!a_dtack_n && !a_vpa_n)) begin
      bad++;
      $display("FAIL excl: dtack_n=%b vpa_n=%b berr_n=%b want no overlap",
               a_dtack_n, a_vpa_n, a_berr_n);
    end
  endtask

  localparam logic [14:0] IDLE_V = 15'b111_000_00_000_0000;

  vec_t tbl[17];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] e_rom, e_romd, e_ram, e_ramd, e_acia, e_aciav;
    e_rom   = mk(1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 4'd0);
    e_romd  = mk(0, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 4'd0);
    e_ram   = mk(1, 1, 1, 0, 1, 1, 2'b10, 0, 0, 0, 4'd0);
    e_ramd  = mk(0, 1, 1, 0, 1, 1, 2'b10, 0, 0, 0, 4'd0);
    e_acia  = mk(1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 4'd0);
    e_aciav = mk(1, 0, 1, 0, 0, 0, 2'b00, 0, 1, 0, 4'd0);

    //               name            as rw u  l  vma pg     expected
    tbl[0]  = mv("rom_k",          0, 1, 0, 0, 1, 4'd0, e_rom);
    tbl[1]  = mv("rom_k1",         0, 1, 0, 0, 1, 4'd0, e_rom);
    tbl[2]  = mv("rom_dtack_k2",   0, 1, 0, 0, 1, 4'd0, e_romd);
    tbl[3]  = mv("rom_hold",       0, 1, 0, 0, 1, 4'd0, e_romd);
    tbl[4]  = mv("rom_release",    1, 1, 1, 1, 1, 4'd0, IDLE_V);
    tbl[5]  = mv("arm1",           1, 1, 1, 1, 1, 4'd0, IDLE_V);
    tbl[6]  = mv("ram_wr_k",       0, 0, 0, 1, 1, 4'd1, e_ram);
    tbl[7]  = mv("ram_dtack_k1",   0, 0, 0, 1, 1, 4'd1, e_ramd);
    tbl[8]  = mv("ram_release",    1, 0, 0, 1, 1, 4'd1, IDLE_V);
    tbl[9]  = mv("arm2",           1, 1, 1, 1, 1, 4'd1, IDLE_V);
    tbl[10] = mv("acia_k",         0, 1, 0, 0, 1, 4'd3, e_acia);
    tbl[11] = mv("acia_wait",      0, 1, 0, 0, 1, 4'd3, e_acia);
    tbl[12] = mv("acia_vma",       0, 1, 0, 0, 0, 4'd3, e_aciav);
    tbl[13] = mv("acia_latched",   0, 1, 0, 0, 0, 4'd2, e_aciav);
    tbl[14] = mv("acia_vma_off",   0, 1, 0, 0, 1, 4'd3, e_acia);
    tbl[15] = mv("acia_release",   1, 1, 1, 1, 1, 4'd3, IDLE_V);
    tbl[16] = mv("arm3",           1, 1, 1, 1, 1, 4'd3, IDLE_V);

    // Reset state, held asynchronously.
    #12;
    chk("reset_a", a_vec, IDLE_V);
    chk("reset_b", b_vec, IDLE_V);
    #3 rst_n = 1'b1;
    tick();
    tick();

    // Tests 1-3: table-driven.
    for (int i = 0; i < 17; i++) begin
      as_n = tbl[i].as_n; rw = tbl[i].rw; uds_n = tbl[i].uds_n;
      lds_n = tbl[i].lds_n; vma_n = tbl[i].vma_n; page = tbl[i].page;
      tick();
      chk(tbl[i].name, a_vec, tbl[i].exp);
    end

    // Test 4: unmapped page 7, TIMEOUT=20 -> BERR at edge k+21.
    page = 4'd7; as_n = 1'b0;
    tick();
    chk1("unmap_k_berr", a_berr_n, 1'b1);
    for (int i = 1; i <= 20; i++) tick();
    chk1("unmap_k20_berr", a_berr_n, 1'b1);
    chk("unmap_k20_fault", {11'd0, a_fault_page}, 15'd0);
    tick();
    chk("unmap_k21", a_vec, mk(1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'd7));
    as_n = 1'b1;
    tick();
    chk("unmap_release", a_vec, mk(1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 4'd7));
    tick();

    // Test 5a: RAM_WAIT=5 on dut_b, strobe released before the wait ends.
    page = 4'd1; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("b_wait_dtack", b_dtack_n, 1'b1);
    end
    chk1("b_wait_ramcs_k3", b_ram_cs, 1'b1);
    as_n = 1'b1;
    tick();
    chk1("b_abort_ramcs_k4", b_ram_cs, 1'b0);
    chk1("b_abort_dtack_k4", b_dtack_n, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("b_after_abort_dtack", b_dtack_n, 1'b1);
    end

    // Test 5b: async reset mid-cycle (dut_a in TERM with DTACK asserted).
    page = 4'd0; uds_n = 1'b1; lds_n = 1'b1; as_n = 1'b0;
    tick(); tick(); tick();
    chk1("rst_pre_dtack", a_dtack_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_a", a_vec, IDLE_V);
    chk("rst_mid_b", b_vec, IDLE_V);
    #1 rst_n = 1'b1;
    as_n = 1'b1;
    tick(); tick();

    // Test 6: strobe low again right after termination starts no cycle.
    as_n = 1'b0;
    tick(); tick(); tick();
    chk1("b2b_first_dtack", a_dtack_n, 1'b0);
    as_n = 1'b1;
    tick();
    chk("b2b_term_release", a_vec, IDLE_V);
    as_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b_no_restart", a_vec, IDLE_V);
    end
    as_n = 1'b1;
    tick();
    as_n = 1'b0;
    tick();
    chk("b2b_new_cycle", a_vec, e_rom);
    as_n = 1'b1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
